rr_arbiter32_enc: RTL
=====================

Name: rr_arbiter32_enc

Overview:
- 32-requester round-robin arbiter. Emits the winner as a registered 5-bit binary index with a valid/ready handshake.
- Sits directly upstream of decoder5to32: Grant_idx drives the decoder's Data_in, and the decoder's 32-bit one-hot output becomes the per-requester grant/enable vector.
- Fairness is by a rotating priority pointer. Each grant is held stable until the consumer accepts it.

Parameters:
- PTR_INIT, 0, reset value of the priority pointer (0..31); the first search starts at this index.
- (localparam) IDX_W, 5, index width. Fixed because the consumer is a 5x32 decoder.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- Req  input  32  request vector; bit i high = requester i wants service.
- Grant_ready  input  1  consumer accepts the current grant this cycle.
- Grant_valid  output  1  Grant_idx holds a valid winner.
- Grant_idx  output  5  binary index of the granted requester.
- Ptr_out  output  5  current priority pointer, for debug/visibility.

Behaviour:
- Reset: synchronous, active-high. On a Clk edge with Rst=1: Grant_valid=0, Grant_idx=0, Ptr=PTR_INIT. Rst overrides every other input, including a pending handshake. A grant in flight is dropped and no pointer update occurs.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM has two states:
  - IDLE: Grant_valid=0.
  - GRANT: Grant_valid=1.
- IDLE:
  - If Req==0, stay in IDLE.
  - Otherwise, winner = first set bit of Req scanning Ptr, Ptr+1, …, 31, 0, …, Ptr-1 (mod 32).
  - Next cycle: GRANT, Grant_idx=winner. Request-to-valid latency is 1 cycle.
- GRANT, Grant_ready=0:
  - Grant_idx and Grant_valid held.
  - Grant is sticky: deassertion of Req[Grant_idx] does not revoke it.
  - Ptr is unchanged.
- GRANT, Grant_ready=1 (accept):
  - Ptr <= Grant_idx+1 mod 32; index 31 wraps to 0.
  - In the same cycle, a new winner is searched from the new pointer value (Grant_idx+1) over the current Req.
  - If Req!=0: stay in GRANT with the new Grant_idx. Back-to-back grants, one per cycle, are supported.
  - If Req==0: go to IDLE, Grant_valid=0, Grant_idx holds its last value.
- Just-granted requester: it has the lowest priority in the next search. It wins again only if it is the sole requester.
- Grant_ready while in IDLE is ignored.
- Ptr changes only on accept or reset. A pointer value outside 0..31 cannot occur (5-bit wrap).
- Req bits for the winner are sampled in the cycle the search happens; later changes do not alter a held grant.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds input port Lock (1 bit).
  - If Lock=1 in an accept cycle and Req[Grant_idx]=1, the same index is re-granted next cycle regardless of pointer order, and Ptr is not advanced.
  - Used for multi-beat bursts.
  - With Lock=1 and Req[Grant_idx]=0, normal round-robin behaviour applies.
- Undefined: no Lock port; pure round-robin as above.

Test Plan:
- Reset, then Req=32'h0000_0001, Grant_ready=0 -> one cycle later Grant_valid=1, Grant_idx=0. Held for 5 cycles; Ptr_out stays 0.
- Req=32'hFFFF_FFFF, Grant_ready=1 continuously from reset -> Grant_idx sequence 0,1,2,…,31,0 on consecutive cycles. Ptr_out wraps 31->0.
- Ptr=5 (after grant 4 accepted), Req=32'h0000_0011 -> Grant_idx=4? No: the search starts at 5, so Grant_idx=4 only if bit 4 is the sole remaining request. Here it yields 4 after 16? Check: bits 0 and 4 are set, scan from 5 wraps to 0 -> Grant_idx=0, then the next accept gives 4.
- Grant at idx=7 with Grant_ready=0, then Req[7] dropped -> Grant_idx stays 7 and Grant_valid stays 1 until Grant_ready=1. Then IDLE if Req==0.
- Rst=1 asserted while Grant_valid=1, Grant_idx=12 -> next cycle Grant_valid=0, Grant_idx=0, Ptr_out=PTR_INIT. No accept is recorded.
- With RR_ARB_LOCK_EN: Req=32'h0000_0300, grant 8 accepted with Lock=1 for 3 beats -> Grant_idx 8,8,8. Then Lock=0 -> 9.

Source files
------------

// File: rtl/rr_arbiter32_enc.sv
// 32-way round-robin arbiter; the winner is a registered 5-bit index
// with a valid/ready handshake, meant to feed a 5-to-32 decoder.
//
// Ports:
//   Clk         rising-edge clock
//   Rst         synchronous active-high reset
//   Req[31:0]   request vector, bit i = requester i
//   Grant_ready consumer accepts the current grant
//   Grant_valid Grant_idx holds a valid winner
//   Grant_idx   binary index of the granted requester
//   Ptr_out     current priority pointer (debug)
//   Lock        only when RR_ARB_LOCK_EN is defined: on an
//               accept, re-grant the same index while it still
//               requests (multi-beat bursts)
//
// Parameter PTR_INIT: pointer value after reset.

module rr_arbiter32_enc #(
  parameter logic [4:0] PTR_INIT = 5'd0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Req,
  input  logic        Grant_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic        Lock,
`endif
  output logic        Grant_valid,
  output logic [4:0]  Grant_idx,
  output logic [4:0]  Ptr_out
);

  localparam int IDX_W = 5;
  localparam int N     = 32;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic               accept;
  logic               lock_hit;
  logic [IDX_W-1:0]   search_ptr;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;

  // On accept the search already starts from the
  // post-accept pointer so back-to-back grants work.
  always_comb begin
    accept     = (state_q == ST_GRANT) && Grant_ready;
    search_ptr = accept ? idx_q + 5'd1 : ptr_q;
`ifdef RR_ARB_LOCK_EN
    lock_hit   = accept && Lock && Req[idx_q];
`else
    lock_hit   = 1'b0;
`endif
  end

  // First set bit scanning search_ptr upwards, 5-bit wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = search_ptr + IDX_W'(i);
      if (!win_found && Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_GRANT;
          idx_d   = win_idx;
        end
      end
      ST_GRANT: begin
        // Locked accept: same index again, pointer frozen.
        if (accept && !lock_hit) begin
          ptr_d = idx_q + 5'd1;
          if (win_found) begin
            idx_d = win_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= PTR_INIT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Grant_valid = (state_q == ST_GRANT);
  assign Grant_idx   = idx_q;
  assign Ptr_out     = ptr_q;

endmodule
